// File: rtl/aximm_follower_app.sv
// aximm_follower_app
// Follower-side AXI-MM responder. It terminates one burst at a time against a
// small word-addressed register memory. Writes arrive on AW/W and answer on B.
// Reads arrive on AR and stream stored words on R.
//
// Ports
//   clk, rst_n          : single clock, asynchronous active-low reset
//   user_aw*            : write address (only awid and awaddr are used)
//   user_w*             : write data with byte strobes; the burst ends on wlast
//   user_b*             : write response (bresp is always OKAY)
//   user_ar*            : read address (arid, araddr and arlen are used)
//   user_r*             : read data; rdata is read combinationally from memory
//   wr_done / rd_done   : one-cycle pulses on the B handshake / last R handshake
//   wr_beats            : W beats accepted in the most recent write burst
//   dbg_state           : current FSM state (0 idle, 1 wr_data, 2 wr_resp, 3 rd_data)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A source holds valid and its payload stable until that
// edge. Every ready output is decoded from the state alone. The one exception
// is arready, which is also gated by awvalid so that a write wins over a
// read requested in the same cycle.
module aximm_follower_app #(
  parameter int DWIDTH     = 128,
  parameter int ADDRWIDTH  = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             user_awid,
  input  logic [2:0]             user_awsize,
  input  logic [7:0]             user_awlen,
  input  logic [1:0]             user_awburst,
  input  logic [ADDRWIDTH-1:0]   user_awaddr,
  input  logic                   user_awvalid,
  output logic                   user_awready,
  input  logic [3:0]             user_wid,
  input  logic [DWIDTH-1:0]      user_wdata,
  input  logic [DWIDTH/8-1:0]    user_wstrb,
  input  logic                   user_wlast,
  input  logic                   user_wvalid,
  output logic                   user_wready,
  output logic [3:0]             user_bid,
  output logic [1:0]             user_bresp,
  output logic                   user_bvalid,
  input  logic                   user_bready,
  input  logic [3:0]             user_arid,
  input  logic [2:0]             user_arsize,
  input  logic [7:0]             user_arlen,
  input  logic [1:0]             user_arburst,
  input  logic [ADDRWIDTH-1:0]   user_araddr,
  input  logic                   user_arvalid,
  output logic                   user_arready,
  output logic [3:0]             user_rid,
  output logic [DWIDTH-1:0]      user_rdata,
  output logic [1:0]             user_rresp,
  output logic                   user_rlast,
  output logic                   user_rvalid,
  input  logic                   user_rready,
  output logic                   wr_done,
  output logic                   rd_done,
  output logic [8:0]             wr_beats,
  output logic [1:0]             dbg_state
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int OFFS   = $clog2(NBYTES);
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [3:0]            id_q, id_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [8:0]            wr_beats_q, wr_beats_d;
  logic [DWIDTH-1:0]     mem_q [DEPTH];
  logic [DWIDTH-1:0]     mem_d [DEPTH];

  logic       aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic [8:0] cnt_inc;

  // Burst attributes other than length and id are ignored. Every burst is
  // handled as INCR with full-word beats.
  logic unused_ok;
  assign unused_ok = ^{user_awsize, user_awlen, user_awburst, user_wid,
                       user_arsize, user_arburst, user_awaddr, user_araddr};

  assign user_awready = (state_q == IDLE);
  assign user_arready = (state_q == IDLE) && !user_awvalid;
  assign user_wready  = (state_q == WR_DATA);
  assign user_bvalid  = (state_q == WR_RESP);
  assign user_rvalid  = (state_q == RD_DATA);

  // One id register serves both channels because only one burst is in flight.
  assign user_bid    = id_q;
  assign user_rid    = id_q;
  assign user_bresp  = 2'b00;
  assign user_rresp  = 2'b00;
  assign user_rdata  = mem_q[idx_q];
  assign user_rlast  = user_rvalid && (cnt_q == {1'b0, arlen_q});

  assign aw_hs = user_awvalid && user_awready;
  assign ar_hs = user_arvalid && user_arready;
  assign w_hs  = user_wvalid  && user_wready;
  assign b_hs  = user_bvalid  && user_bready;
  assign r_hs  = user_rvalid  && user_rready;

  assign wr_done   = b_hs;
  assign rd_done   = r_hs && user_rlast;
  assign wr_beats  = wr_beats_q;
  assign dbg_state = state_q;

  // The beat counter saturates instead of wrapping on very long write bursts.
  assign cnt_inc = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    arlen_d    = arlen_q;
    wr_beats_d = wr_beats_q;
    mem_d      = mem_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = user_awid;
          idx_d   = user_awaddr[OFFS +: DEPTH_LOG2];
          cnt_d   = 9'd0;
          state_d = WR_DATA;
        end else if (ar_hs) begin
          id_d    = user_arid;
          idx_d   = user_araddr[OFFS +: DEPTH_LOG2];
          arlen_d = user_arlen;
          cnt_d   = 9'd0;
          state_d = RD_DATA;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (user_wstrb[b]) mem_d[idx_q][8*b +: 8] = user_wdata[8*b +: 8];
          end
          idx_d = idx_q + DEPTH_LOG2'(1);
          cnt_d = cnt_inc;
          if (user_wlast) begin
            wr_beats_d = cnt_inc;
            state_d    = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (b_hs) state_d = IDLE;
      end
      RD_DATA: begin
        if (r_hs) begin
          idx_d = idx_q + DEPTH_LOG2'(1);
          cnt_d = cnt_inc;
          if (user_rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      arlen_q    <= '0;
      wr_beats_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      arlen_q    <= arlen_d;
      wr_beats_q <= wr_beats_d;
      mem_q      <= mem_d;
    end
  end

endmodule
